// File: rtl/l2_fill_sched.sv
// L2 cache write-port sequencer: arbitrates write-through updates, miss fills and prefetch fills,
// issues 4-beat line reads to the bus and streams the returned beats into the cache.
module l2_fill_sched #(
    parameter int CAW = 28,
    parameter int TMO = 255
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            miss_req,
    input  logic [CAW-3:0]  miss_a,
    output logic            miss_done,
    output logic            miss_err,
    input  logic            pf_req,
    input  logic [CAW-3:0]  pf_a,
    output logic            pf_done,
    output logic            pf_drop,
    input  logic            wt_req,
    input  logic [CAW-1:0]  wt_a,
    input  logic [31:0]     wt_d,
    input  logic [3:0]      wt_m,
    output logic            wt_ack,
    output logic            bus_req,
    output logic [CAW-3:0]  bus_a,
    input  logic            bus_ack,
    input  logic            bus_dv,
    input  logic [31:0]     bus_d,
    input  logic            bus_err,
    output logic [CAW-1:0]  WRA,
    output logic [31:0]     WRD,
    output logic [3:0]      WRM,
    output logic            WR,
    output logic            TS,
    output logic            CLR,
    output logic            ALL
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    typedef enum logic [2:0] {
        S_INIT, S_ICLR, S_IDLE, S_REQ, S_FILL, S_FIN, S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic            owner_miss_reg;
    logic            merged_reg;
    logic            fail_reg;
    logic [CAW-3:0]  line_reg;
    logic [1:0]      beat_reg;
    logic [7:0]      tmo_reg;

    logic            wr_reg, wr_next;
    logic            ts_reg, ts_next;
    logic            clr_reg, clr_next;
    logic            all_reg, all_next;
    logic            wt_ack_reg, wt_ack_next;
    logic [CAW-1:0]  wra_reg, wra_next;
    logic [31:0]     wrd_reg, wrd_next;
    logic [3:0]      wrm_reg, wrm_next;

    logic wt_go, miss_go, pf_go, preempt, merge_hit, beat_ok, fill_fail, last_beat;

    // wt_ack is registered, so the request is still high the cycle it is acknowledged
    always_comb begin
        wt_go     = (state_reg == S_IDLE) && wt_req && !wt_ack_reg;
        miss_go   = (state_reg == S_IDLE) && !wt_go && miss_req;
        pf_go     = (state_reg == S_IDLE) && !wt_go && !miss_req && pf_req;
        preempt   = (state_reg == S_REQ) && !owner_miss_reg && miss_req &&
                    (miss_a != line_reg) && !bus_ack;
        merge_hit = ((state_reg == S_REQ) || (state_reg == S_FILL)) && !owner_miss_reg &&
                    miss_req && (miss_a == line_reg);
        beat_ok   = (state_reg == S_FILL) && bus_dv && !bus_err;
        fill_fail = (state_reg == S_FILL) && (bus_err || (!bus_dv && (tmo_reg == TMO_LAST)));
        last_beat = beat_ok && (beat_reg == 2'd3);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:  state_next = S_ICLR;
            S_ICLR:  state_next = S_IDLE;
            S_IDLE:  if (miss_go || pf_go) state_next = S_REQ;
            S_REQ:   if (bus_ack) state_next = S_FILL;
            S_FILL:  if (fill_fail || last_beat) state_next = S_FIN;
            S_FIN:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    always_comb begin
        wr_next     = 1'b0;
        ts_next     = 1'b0;
        clr_next    = 1'b0;
        all_next    = 1'b0;
        wt_ack_next = 1'b0;
        wra_next    = wra_reg;
        wrd_next    = wrd_reg;
        wrm_next    = wrm_reg;
        if (state_reg == S_INIT) begin
            clr_next = 1'b1;
            all_next = 1'b1;
        end
        if (wt_go) begin
            wr_next     = 1'b1;
            wt_ack_next = 1'b1;
            wra_next    = wt_a;
            wrd_next    = wt_d;
            wrm_next    = wt_m;
        end
        if (beat_ok) begin
            wr_next  = 1'b1;
            ts_next  = (beat_reg == 2'd3);
            wra_next = {line_reg, beat_reg};
            wrd_next = bus_d;
            wrm_next = 4'hF;
        end
        // a failed fill invalidates the line instead of validating the tag
        if (fill_fail) begin
            clr_next = 1'b1;
            wra_next = {line_reg, 2'b00};
        end

        bus_req   = (state_reg == S_REQ);
        bus_a     = preempt ? miss_a : line_reg;
        pf_drop   = preempt;
        miss_done = (state_reg == S_DONE) && (owner_miss_reg || merged_reg);
        pf_done   = (state_reg == S_DONE) && !owner_miss_reg;
        miss_err  = miss_done && fail_reg;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            owner_miss_reg <= 1'b0;
            merged_reg     <= 1'b0;
            fail_reg       <= 1'b0;
            line_reg       <= '0;
            beat_reg       <= '0;
            tmo_reg        <= '0;
            wr_reg         <= 1'b0;
            ts_reg         <= 1'b0;
            clr_reg        <= 1'b0;
            all_reg        <= 1'b0;
            wt_ack_reg     <= 1'b0;
            wra_reg        <= '0;
            wrd_reg        <= '0;
            wrm_reg        <= '0;
        end else begin
            wr_reg     <= wr_next;
            ts_reg     <= ts_next;
            clr_reg    <= clr_next;
            all_reg    <= all_next;
            wt_ack_reg <= wt_ack_next;
            wra_reg    <= wra_next;
            wrd_reg    <= wrd_next;
            wrm_reg    <= wrm_next;
            if (miss_go || pf_go) begin
                owner_miss_reg <= miss_go;
                line_reg       <= miss_go ? miss_a : pf_a;
                merged_reg     <= 1'b0;
                fail_reg       <= 1'b0;
            end
            if (preempt) begin
                owner_miss_reg <= 1'b1;
                line_reg       <= miss_a;
            end
            if (merge_hit) begin
                merged_reg <= 1'b1;
            end
            if ((state_reg == S_REQ) && bus_ack) begin
                beat_reg <= '0;
                tmo_reg  <= '0;
            end
            if (beat_ok) begin
                beat_reg <= beat_reg + 2'd1;
                tmo_reg  <= '0;
            end else if ((state_reg == S_FILL) && !bus_err) begin
                tmo_reg <= tmo_reg + 8'd1;
            end
            if (fill_fail) begin
                fail_reg <= 1'b1;
            end
        end
    end

    assign WR     = wr_reg;
    assign TS     = ts_reg;
    assign CLR    = clr_reg;
    assign ALL    = all_reg;
    assign WRA    = wra_reg;
    assign WRD    = wrd_reg;
    assign WRM    = wrm_reg;
    assign wt_ack = wt_ack_reg;

endmodule

// File: tb/tb_l2_fill_sched.sv
// Bench for l2_fill_sched: directed scenarios plus randomized fills checked against a beat-level model.
module tb_l2_fill_sched;

    localparam int CAW = 28;
    localparam int TMO = 255;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            miss_req, pf_req, wt_req, bus_ack, bus_dv, bus_err;
    logic [CAW-3:0]  miss_a, pf_a;
    logic [CAW-1:0]  wt_a;
    logic [31:0]     wt_d, bus_d;
    logic [3:0]      wt_m;
    logic            miss_done, miss_err, pf_done, pf_drop, wt_ack, bus_req;
    logic [CAW-3:0]  bus_a;
    logic [CAW-1:0]  WRA;
    logic [31:0]     WRD;
    logic [3:0]      WRM;
    logic            WR, TS, CLR, ALL;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] beat_d [4];

    always #5 CLK = ~CLK;

    l2_fill_sched #(.CAW(CAW), .TMO(TMO)) dut (
        .CLK(CLK), .nRST(nRST),
        .miss_req(miss_req), .miss_a(miss_a), .miss_done(miss_done), .miss_err(miss_err),
        .pf_req(pf_req), .pf_a(pf_a), .pf_done(pf_done), .pf_drop(pf_drop),
        .wt_req(wt_req), .wt_a(wt_a), .wt_d(wt_d), .wt_m(wt_m), .wt_ack(wt_ack),
        .bus_req(bus_req), .bus_a(bus_a), .bus_ack(bus_ack), .bus_dv(bus_dv),
        .bus_d(bus_d), .bus_err(bus_err),
        .WRA(WRA), .WRD(WRD), .WRM(WRM), .WR(WR), .TS(TS), .CLR(CLR), .ALL(ALL)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        logic acc;
        acc = 1'b0;
        @(negedge CLK);
        nRST = 1'b0; miss_req = 0; pf_req = 0; wt_req = 0; bus_ack = 0; bus_dv = 0; bus_err = 0;
        repeat (3) begin
            @(negedge CLK); #1;
            acc = acc | WR | CLR | ALL | TS | wt_ack | bus_req | miss_done | miss_err |
                  pf_done | pf_drop | (|WRA) | (|WRD) | (|WRM) | (|bus_a);
        end
        chk("reset_outputs_zero", 32'(acc), 32'(0));
        @(negedge CLK); nRST = 1'b1; #1;
        @(negedge CLK); #1;
        chk("init_clr", 32'(CLR), 32'(1));
        chk("init_all", 32'(ALL), 32'(1));
        chk("init_wr", 32'(WR), 32'(0));
        chk("init_acks", 32'(wt_ack | bus_req | miss_done | pf_done | pf_drop), 32'(0));
        @(negedge CLK); #1;
        chk("init_clr_once", 32'(CLR | ALL), 32'(0));
    endtask

    // Raise a request in IDLE, expect bus_req one cycle later, then ack after a random wait
    task automatic issue(input bit own_miss, input logic [CAW-3:0] line);
        int n;
        @(negedge CLK);
        if (own_miss) begin miss_req = 1'b1; miss_a = line; end
        else begin pf_req = 1'b1; pf_a = line; end
        #1;
        chk("idle_no_busreq", 32'(bus_req), 32'(0));
        @(negedge CLK); #1;
        chk("busreq_lat1", 32'(bus_req), 32'(1));
        chk("bus_a", 32'(bus_a), 32'(line));
        n = $urandom_range(0, 2);
        repeat (n) begin
            @(negedge CLK); #1;
            chk("busreq_hold", 32'(bus_req), 32'(1));
        end
        bus_ack = 1'b1;
    endtask

    // mode 0: clean fill, 1: bus_err at err_beat, 2: no beats until timeout
    task automatic fill_phase(input logic [CAW-3:0] line, input bit own_miss, input int mode,
                              input int err_beat, input bit err_dv, input bit do_merge,
                              input bit do_wt);
        int beat, cyc;
        bit fin, pend, pts, exp_md, exp_pd;
        logic [CAW-1:0] pa, wa;
        logic [31:0] pd, wd;
        logic [3:0] wm;
        logic bad_req, bad_ack, bad_done, early_clr;
        beat = 0; cyc = 0; fin = 0; pend = 0; pts = 0; pa = '0; pd = '0;
        bad_req = 0; bad_ack = 0; bad_done = 0; early_clr = 0;
        wa = CAW'($urandom); wd = $urandom; wm = 4'($urandom_range(1, 15));
        while (!fin) begin
            @(negedge CLK);
            bus_ack = 0; bus_dv = 0; bus_err = 0; bus_d = $urandom;
            if (cyc == 0 && do_merge) begin miss_req = 1'b1; miss_a = line; end
            if (cyc == 0 && do_wt) begin wt_req = 1'b1; wt_a = wa; wt_d = wd; wt_m = wm; end
            if (mode != 2 && $urandom_range(0, 2) != 0) begin
                if (mode == 1 && beat == err_beat) begin
                    bus_err = 1'b1; bus_dv = err_dv; fin = 1;
                end else begin
                    bus_dv = 1'b1; bus_d = beat_d[beat];
                end
            end
            #1;
            chk("fill_wr", 32'(WR), 32'(pend));
            if (pend) begin
                chk("fill_wra", 32'(WRA), 32'(pa));
                chk("fill_wrd", WRD, pd);
                chk("fill_wrm", 32'(WRM), 32'hF);
                chk("fill_ts", 32'(TS), 32'(pts));
            end
            bad_req   = bad_req | bus_req;
            bad_ack   = bad_ack | wt_ack;
            bad_done  = bad_done | miss_done | pf_done | pf_drop;
            early_clr = early_clr | CLR;
            pend = bus_dv && !bus_err;
            if (pend) begin
                pa = {line, 2'b00} + CAW'(beat);
                pd = bus_d;
                pts = (beat == 3);
                beat++;
                if (beat == 4) fin = 1;
            end
            cyc++;
            if (mode == 2 && cyc == TMO) fin = 1;
            if (cyc > 2000) fin = 1;
        end
        chk("fill_bound", 32'(cyc > 2000), 32'(0));
        chk("fill_no_busreq", 32'(bad_req), 32'(0));
        chk("fill_no_wtack", 32'(bad_ack), 32'(0));
        chk("fill_no_done", 32'(bad_done), 32'(0));
        chk("fill_no_early_clr", 32'(early_clr), 32'(0));
        @(negedge CLK); bus_dv = 0; bus_err = 0; #1;
        if (mode == 0) begin
            chk("last_wr", 32'(WR), 32'(1));
            chk("last_wra", 32'(WRA), 32'(pa));
            chk("last_wrd", WRD, pd);
            chk("last_ts", 32'(TS), 32'(1));
            chk("last_clr", 32'(CLR), 32'(0));
        end else begin
            chk("fail_clr", 32'(CLR), 32'(1));
            chk("fail_all", 32'(ALL), 32'(0));
            chk("fail_wr", 32'(WR), 32'(0));
            chk("fail_wra", 32'(WRA), 32'({line, 2'b00}));
        end
        chk("fin_no_done", 32'(miss_done | pf_done | wt_ack), 32'(0));
        exp_md = own_miss || do_merge;
        exp_pd = !own_miss;
        @(negedge CLK); #1;
        chk("miss_done", 32'(miss_done), 32'(exp_md));
        chk("pf_done", 32'(pf_done), 32'(exp_pd));
        chk("miss_err", 32'(miss_err), 32'((mode != 0) && exp_md));
        chk("done_no_wr", 32'(WR | CLR | wt_ack), 32'(0));
        if (exp_md) miss_req = 1'b0;
        if (exp_pd) pf_req = 1'b0;
        @(negedge CLK); #1;
        chk("done_once", 32'(miss_done | pf_done), 32'(0));
        chk("idle_wt_wait", 32'(wt_ack), 32'(0));
        if (do_wt) begin
            @(negedge CLK); #1;
            chk("wt_after_ack", 32'(wt_ack), 32'(1));
            chk("wt_after_wr", 32'(WR), 32'(1));
            chk("wt_after_wra", 32'(WRA), 32'(wa));
            chk("wt_after_wrd", WRD, wd);
            chk("wt_after_wrm", 32'(WRM), 32'(wm));
            wt_req = 1'b0;
            @(negedge CLK); #1;
            chk("wt_ack_once", 32'(wt_ack), 32'(0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed still running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [CAW-3:0] ln, ln2;
        logic [CAW-1:0] wa;
        logic [31:0] wd;
        bit om, mg, wtd, edv;
        int md, eb;
        nRST = 0; miss_req = 0; pf_req = 0; wt_req = 0; bus_ack = 0; bus_dv = 0; bus_err = 0;
        miss_a = '0; pf_a = '0; wt_a = '0; wt_d = '0; wt_m = '0; bus_d = '0;

        do_reset();

        // Known line and beat data: WRA runs 0x048D158..0x048D15B
        for (int i = 0; i < 4; i++) beat_d[i] = 32'hA0 + 32'(i);
        issue(1'b1, 26'h0123456);
        fill_phase(26'h0123456, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Write-through wins over a simultaneous prefetch
        ln = 26'($urandom); wa = 28'($urandom); wd = $urandom;
        for (int i = 0; i < 4; i++) beat_d[i] = $urandom;
        @(negedge CLK);
        pf_req = 1'b1; pf_a = ln; wt_req = 1'b1; wt_a = wa; wt_d = wd; wt_m = 4'h5;
        #1;
        chk("wtpf_first_busreq", 32'(bus_req), 32'(0));
        @(negedge CLK); #1;
        chk("wtpf_wt_ack", 32'(wt_ack), 32'(1));
        chk("wtpf_wr", 32'(WR), 32'(1));
        chk("wtpf_wra", 32'(WRA), 32'(wa));
        chk("wtpf_wrd", WRD, wd);
        chk("wtpf_wrm", 32'(WRM), 32'h5);
        chk("wtpf_ts", 32'(TS), 32'(0));
        chk("wtpf_busreq_wait", 32'(bus_req), 32'(0));
        wt_req = 1'b0;
        @(negedge CLK); #1;
        chk("wtpf_busreq", 32'(bus_req), 32'(1));
        chk("wtpf_bus_a", 32'(bus_a), 32'(ln));
        chk("wtpf_ack_once", 32'(wt_ack), 32'(0));
        bus_ack = 1'b1;
        fill_phase(ln, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Miss preempts a prefetch that has not been accepted yet
        ln = 26'($urandom); ln2 = ln ^ 26'h1;
        for (int i = 0; i < 4; i++) beat_d[i] = $urandom;
        @(negedge CLK); pf_req = 1'b1; pf_a = ln; #1;
        @(negedge CLK); #1;
        chk("pre_bus_a_pf", 32'(bus_a), 32'(ln));
        @(negedge CLK); miss_req = 1'b1; miss_a = ln2; #1;
        chk("pre_pf_drop", 32'(pf_drop), 32'(1));
        chk("pre_bus_a_switch", 32'(bus_a), 32'(ln2));
        chk("pre_busreq", 32'(bus_req), 32'(1));
        pf_req = 1'b0;
        @(negedge CLK); #1;
        chk("pre_drop_once", 32'(pf_drop), 32'(0));
        chk("pre_bus_a_miss", 32'(bus_a), 32'(ln2));
        bus_ack = 1'b1;
        fill_phase(ln2, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Miss to the in-flight prefetch line merges into it
        ln = 26'($urandom);
        for (int i = 0; i < 4; i++) beat_d[i] = $urandom;
        issue(1'b0, ln);
        fill_phase(ln, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

        // bus_err on beat 2, then a write-through queued behind the failed fill
        ln = 26'($urandom);
        issue(1'b1, ln);
        fill_phase(ln, 1'b1, 1, 2, 1'b1, 1'b0, 1'b1);

        // No beats at all: timeout
        ln = 26'($urandom);
        issue(1'b1, ln);
        fill_phase(ln, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);

        // Reset mid-fill abandons it silently
        ln = 26'($urandom);
        issue(1'b1, ln);
        @(negedge CLK); bus_ack = 0; bus_dv = 1'b1; bus_d = $urandom; #1;
        do_reset();

        for (int r = 0; r < 14; r++) begin
            om  = 1'($urandom_range(0, 1));
            ln  = 26'($urandom);
            md  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            eb  = $urandom_range(0, 3);
            edv = 1'($urandom_range(0, 1));
            mg  = !om && ($urandom_range(0, 1) == 1);
            wtd = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) beat_d[i] = $urandom;
            issue(om, ln);
            fill_phase(ln, om, md, eb, edv, mg, wtd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
